// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic               neg_res_r;
    logic               busy_r, done_r, dbz_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               accept_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   hi_res_s, lo_res_s;
`ifdef MULDIV_DIV_EN
    logic               is_div_r, neg_rem_r, dbz_pend_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [WIDTH:0]     sub_s;

    assign accept_s = (state_r == ST_IDLE) && start_i && !flush_i;
`else
    assign accept_s = (state_r == ST_IDLE) && start_i && !flush_i && !op_i[1];
`endif

    // Operand magnitudes: two's-complement absolute value for signed ops.
    always_comb begin
        mag_a_s = a_i;
        mag_b_s = b_i;
        if (op_i[0] && a_i[WIDTH-1]) mag_a_s = -a_i;
        else                         mag_a_s = a_i;
        if (op_i[0] && b_i[WIDTH-1]) mag_b_s = -b_i;
        else                         mag_b_s = b_i;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        add_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        acc_next_s = {add_s, acc_r[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        sub_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opb_r};
        if (is_div_r) begin
            if (!sub_s[WIDTH]) acc_next_s = {sub_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            else               acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_next_s = {add_s, acc_r[WIDTH-1:1]};
        end
`endif
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        if (neg_res_r) prod_s = -acc_r;
        else           prod_s = acc_r;
        hi_res_s = prod_s[2*WIDTH-1:WIDTH];
        lo_res_s = prod_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_r && dbz_pend_r) begin
            hi_res_s = a_raw_r;
            lo_res_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            hi_res_s = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
            lo_res_s = neg_res_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        end else begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // Control FSM, operand capture and iteration datapath; flush wins over everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            neg_res_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_r   <= 1'b0;
            neg_rem_r  <= 1'b0;
            dbz_pend_r <= 1'b0;
            a_raw_r    <= {WIDTH{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            if (flush_i) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            state_r   <= ST_CALC;
                            busy_r    <= 1'b1;
                            cnt_r     <= {CNT_W{1'b0}};
                            acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
                            opb_r     <= mag_b_s;
                            neg_res_r <= op_i[0] & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                            is_div_r   <= op_i[1];
                            neg_rem_r  <= op_i[0] & a_i[WIDTH-1];
                            dbz_pend_r <= (b_i == {WIDTH{1'b0}});
                            a_raw_r    <= a_i;
`endif
                        end
                    end
                    ST_CALC: begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + 1'b1;
                        if (cnt_r == CNT_W'(WIDTH - 1)) state_r <= ST_FIX;
                        else                            state_r <= ST_CALC;
                    end
                    ST_FIX: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`ifdef MULDIV_DIV_EN
                        dbz_r   <= is_div_r & dbz_pend_r;
`endif
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // HI/LO: result write on completion, MTHI/MTLO only while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_FIX && !flush_i) begin
            hi_r <= hi_res_s;
            lo_r <= lo_res_s;
        end else if (state_r == ST_IDLE) begin
            if (wr_hi_i) hi_r <= wdata_i;
            if (wr_lo_i) lo_r <= wdata_i;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign dbz_o  = dbz_r;
    assign hi_o   = hi_r;
    assign lo_o   = lo_r;
endmodule
